// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: function codes, FSM states,
// iterative-unit operation select and PSR bit positions.
package alu_pkg;

  localparam logic [3:0] FN_ANDCC  = 4'd0;
  localparam logic [3:0] FN_ORCC   = 4'd1;
  localparam logic [3:0] FN_NORCC  = 4'd2;
  localparam logic [3:0] FN_ADDCC  = 4'd3;
  localparam logic [3:0] FN_SUBCC  = 4'd4;
  localparam logic [3:0] FN_AND    = 4'd5;
  localparam logic [3:0] FN_OR     = 4'd6;
  localparam logic [3:0] FN_NOR    = 4'd7;
  localparam logic [3:0] FN_ADD    = 4'd8;
  localparam logic [3:0] FN_SUB    = 4'd9;
  localparam logic [3:0] FN_SIMM13 = 4'd10;
  localparam logic [3:0] FN_SEXT13 = 4'd11;
  localparam logic [3:0] FN_SLL    = 4'd12;
  localparam logic [3:0] FN_SRL    = 4'd13;
  localparam logic [3:0] FN_SRA    = 4'd14;
  localparam logic [3:0] FN_MULCC  = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
  typedef enum logic [1:0] {IT_SLL, IT_SRL, IT_SRA, IT_MUL} iter_op_t;

  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

endpackage

// File: rtl/alu_iter.sv
// Iterative engine: one-bit-per-step shifter and radix-2 shift-add multiplier
// sharing a 2*WIDTH accumulator (the low half doubles as the shift register).
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  iter_op_t         op,
  input  logic [SHW-1:0]   n,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  iter_op_t           op_q, op_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  function automatic logic [2*WIDTH-1:0] advance(input logic [2*WIDTH-1:0] acc,
                                                 input iter_op_t o,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0]          sum;
    logic [WIDTH-1:0]        lo;
    logic signed [WIDTH-1:0] slo;
    lo  = acc[WIDTH-1:0];
    slo = lo;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (lo[0] ? m : {WIDTH{1'b0}})};
    case (o)
      IT_SLL:  advance = {acc[2*WIDTH-1:WIDTH], lo << 1};
      IT_SRL:  advance = {acc[2*WIDTH-1:WIDTH], lo >> 1};
      IT_SRA:  advance = {acc[2*WIDTH-1:WIDTH], slo >>> 1};
      default: advance = {sum, lo[WIDTH-1:1]};
    endcase
  endfunction

  assign acc_next = advance(acc_q, op_q, mcand_q);

  // The load cycle already performs the first step, so the counter holds
  // the number of steps still outstanding.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (load) begin
      op_d    = op;
      mcand_d = a;
      acc_d   = advance((op == IT_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a}, op, a);
      cnt_d   = (op == IT_MUL) ? SHW'(WIDTH - 1) : n - SHW'(1);
    end else if (step) begin
      acc_d = acc_next;
      cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    op_q    <= op_d;
  end

  assign last  = (cnt_q == SHW'(1));
  assign res   = acc_next[WIDTH-1:0];
  assign hi_nz = |acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/done handshake: single-cycle logic/arith ops,
// iterative shifts and unsigned multiply, registered result and PSR.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] busC,
  output logic [3:0]       psr
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] busc_q, busc_d;
  logic [3:0]       psr_q, psr_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   n;
  logic             is_shift, accept, it_load, it_step, it_last, it_hinz;
  iter_op_t         it_op;
  logic [WIDTH-1:0] it_res, res_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic signed [WIDTH-1:0] sa_s;
  logic             v_s, c_s;

  function automatic logic [3:0] mk_psr(input logic [WIDTH-1:0] r, input logic v, input logic c);
    mk_psr        = 4'b0000;
    mk_psr[PSR_N] = r[WIDTH-1];
    mk_psr[PSR_Z] = (r == '0);
    mk_psr[PSR_V] = v;
    mk_psr[PSR_C] = c;
  endfunction

  assign n        = busB[SHW-1:0];
  assign is_shift = (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
  assign accept   = (state_q == ST_IDLE) && start;

  always_comb begin
    case (func)
      FN_SLL:  it_op = IT_SLL;
      FN_SRL:  it_op = IT_SRL;
      FN_SRA:  it_op = IT_SRA;
      default: it_op = IT_MUL;
    endcase
  end

  // Single-cycle datapath; shifts by 0 or 1 also finish here.
  always_comb begin
    sum_s  = {1'b0, busA} + {1'b0, busB};
    diff_s = busA + ~busB + WIDTH'(1);
    sa_s   = busA;
    res_s  = '0;
    v_s    = 1'b0;
    c_s    = 1'b0;
    case (func)
      FN_ANDCC, FN_AND: res_s = busA & busB;
      FN_ORCC,  FN_OR:  res_s = busA | busB;
      FN_NORCC, FN_NOR: res_s = ~(busA | busB);
      FN_ADDCC, FN_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (busA[WIDTH-1] == busB[WIDTH-1]) && (res_s[WIDTH-1] != busA[WIDTH-1]);
      end
      FN_SUBCC, FN_SUB: begin
        res_s = diff_s;
        c_s   = (busA < busB);
        v_s   = (busA[WIDTH-1] != busB[WIDTH-1]) && (res_s[WIDTH-1] != busA[WIDTH-1]);
      end
      FN_SIMM13: res_s = {{(WIDTH-13){1'b0}}, busA[12:0]};
      FN_SEXT13: res_s = {{(WIDTH-13){busA[12]}}, busA[12:0]};
      FN_SLL:    res_s = (n == '0) ? busA : (busA << 1);
      FN_SRL:    res_s = (n == '0) ? busA : (busA >> 1);
      FN_SRA:    res_s = (n == '0) ? busA : (sa_s >>> 1);
      default:   res_s = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && func == FN_MULCC)                state_d = ST_MUL;
        else if (accept && is_shift && n > SHW'(1))    state_d = ST_SHIFT;
      end
      ST_SHIFT, ST_MUL: if (it_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    it_load = accept && ((func == FN_MULCC) || (is_shift && n > SHW'(1)));
    it_step = busy;
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (it_load),
    .op    (it_op),
    .n     (n),
    .step  (it_step),
    .a     (busA),
    .b     (busB),
    .last  (it_last),
    .res   (it_res),
    .hi_nz (it_hinz)
  );

  always_comb begin
    busc_d = busc_q;
    psr_d  = psr_q;
    done_d = 1'b0;
    if (accept && !it_load) begin
      busc_d = res_s;
      done_d = 1'b1;
      if (func <= FN_SUBCC) psr_d = mk_psr(res_s, v_s, c_s);
    end else if (busy && it_last) begin
      busc_d = it_res;
      done_d = 1'b1;
      if (state_q == ST_MUL) psr_d = mk_psr(it_res, it_hinz, 1'b0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busc_q <= '0;
      psr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      busc_q <= busc_d;
      psr_q  <= psr_d;
      done_q <= done_d;
    end
  end

  assign busC = busc_q;
  assign psr  = psr_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: WIDTH=32 and WIDTH=16 instances,
// directed vectors with hand-computed results, flags and latencies.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, start16 = 1'b0;
  logic [3:0]  f32 = '0, f16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy32, done32, busy16, done16;
  logic [31:0] busC32;
  logic [15:0] busC16;
  logic [3:0]  psr32, psr16;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .func(f32), .busA(a32), .busB(b32),
    .busy(busy32), .done(done32), .busC(busC32), .psr(psr32)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .func(f16), .busA(a16), .busB(b16),
    .busy(busy16), .done(done16), .busC(busC16), .psr(psr16)
  );

  typedef struct {
    logic [31:0] c;
    logic [3:0]  p;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_spurious: got done=1 busC=0x%08h expected no completion", busC32);
      end else begin
        e32 = q32.pop_front();
        chk("lat32", cyc, e32.cyc);
        chk("busC32", busC32, e32.c);
        chk("psr32", {28'd0, psr32}, {28'd0, e32.p});
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_spurious: got done=1 busC=0x%04h expected no completion", busC16);
      end else begin
        e16 = q16.pop_front();
        chk("lat16", cyc, e16.cyc);
        chk("busC16", {16'd0, busC16}, e16.c);
        chk("psr16", {28'd0, psr16}, {28'd0, e16.p});
      end
    end
  end

  task automatic issue32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] p, input int lat, input bit push);
    f32 = f; a32 = a; b32 = b; start32 = 1'b1;
    if (push) q32.push_back('{c: c, p: p, cyc: cyc + lat});
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [3:0] p, input int lat);
    f16 = f; a16 = a; b16 = b; start16 = 1'b1;
    q16.push_back('{c: {16'd0, c}, p: p, cyc: cyc + lat});
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic wait_all();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || busy32 || busy16) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d outstanding expected 0", q32.size() + q16.size());
      q32.delete();
      q16.delete();
    end
  endtask

  task automatic op32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [3:0] p, input int lat);
    issue32(f, a, b, c, p, lat, 1'b1);
    wait_all();
  endtask

  task automatic op16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [3:0] p, input int lat);
    issue16(f, a, b, c, p, lat);
    wait_all();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busC", busC32, 32'h0);
    chk("rst_psr", {28'd0, psr32}, 32'h0);
    chk("rst_busy", {31'd0, busy32}, 32'h0);
    chk("rst_done", {31'd0, done32}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op32(FN_ADDCC, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1010, 1);
    op32(FN_SUBCC, 32'd5, 32'd5, 32'h0, 4'b0100, 1);
    op32(FN_SUBCC, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1001, 1);
    op32(FN_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 4'b1001, 1);

    // Iterative shift; a start during busy must be ignored.
    issue32(FN_SRA, 32'h80000000, 32'd4, 32'hF8000000, 4'b1001, 4, 1'b1);
    chk("sra_busy1", {31'd0, busy32}, 32'h1);
    f32 = FN_ADD; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("sra_busy2", {31'd0, busy32}, 32'h1);
    @(posedge clk); #1;
    chk("sra_busy3", {31'd0, busy32}, 32'h1);
    @(posedge clk); #1;
    chk("sra_busy_end", {31'd0, busy32}, 32'h0);
    wait_all();

    op32(FN_SLL, 32'h00001234, 32'd0, 32'h00001234, 4'b1001, 1);
    op32(FN_SRL, 32'h80000000, 32'd1, 32'h40000000, 4'b1001, 1);
    op32(FN_SRA, 32'h40000000, 32'h22, 32'h10000000, 4'b1001, 2);
    op32(FN_SLL, 32'h00000001, 32'd31, 32'h80000000, 4'b1001, 31);

    // Back-to-back single-cycle ops, one per cycle.
    issue32(FN_OR, 32'hA, 32'h5, 32'hF, 4'b1001, 1, 1'b1);
    issue32(FN_NORCC, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b1000, 1, 1'b1);
    issue32(FN_ADD, 32'd1, 32'd2, 32'd3, 4'b1000, 1, 1'b1);
    wait_all();

    op32(FN_SIMM13, 32'hFFFFFFFF, 32'h0, 32'h00001FFF, 4'b1000, 1);
    op32(FN_SEXT13, 32'h00001000, 32'h0, 32'hFFFFF000, 4'b1000, 1);
    op32(FN_MULCC, 32'h00010000, 32'h00010000, 32'h0, 4'b0110, 32);
    op32(FN_MULCC, 32'd7, 32'd6, 32'd42, 4'b0000, 32);
    op32(FN_SUBCC, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1001, 1);

    // Asynchronous reset in the middle of a multiply.
    issue32(FN_MULCC, 32'd5, 32'd5, 32'd0, 4'b0000, 0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busC", busC32, 32'h0);
    chk("midrst_psr", {28'd0, psr32}, 32'h0);
    chk("midrst_busy", {31'd0, busy32}, 32'h0);
    chk("midrst_done", {31'd0, done32}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op32(FN_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1);

    op16(FN_ADDCC, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1);
    op16(FN_SEXT13, 16'h1000, 16'h0000, 16'hF000, 4'b0101, 1);
    op16(FN_SUBCC, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 1);
    op16(FN_MULCC, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 16);
    op16(FN_SRL, 16'h8000, 16'd15, 16'h0001, 4'b0110, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
